// File: rtl/uart_tx.sv
// UART transmitter: start bit, LSB-first data, optional odd parity, one or two stop bits.
// Bit timing is paced by an external oversample strobe; tx_pin is registered so it is glitch-free.
`timescale 1ns/1ps

module uart_tx #(
    parameter int DATA_BITS  = 8,
    parameter int OVS_FACTOR = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 tick_16x,
    input  logic                 tx_valid,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 parity_enable,
    input  logic                 two_stop,
    output logic                 tx_ready,
    output logic                 tx_pin,
    output logic                 tx_busy,
    output logic                 tx_done
);

    localparam int OS_W  = (OVS_FACTOR > 1) ? $clog2(OVS_FACTOR) : 1;
    localparam int IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [OS_W-1:0]  OS_LAST  = OS_W'(OVS_FACTOR - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        DONE
    } state_t;

    state_t               state, state_nxt;
    logic [OS_W-1:0]      os_count, os_count_nxt;
    logic [IDX_W-1:0]     bit_index, bit_index_nxt;
    logic                 stop_second, stop_second_nxt;
    logic [DATA_BITS-1:0] data_q;
    logic                 parity_q;
    logic                 two_stop_q;
    logic                 armed;
    logic                 pin_nxt;
    logic                 accept;
    logic                 bit_end;

    assign accept   = tx_valid && tx_ready;
    assign bit_end  = tick_16x && (os_count == OS_LAST);
    // armed keeps tx_ready low until the first clock edge after reset release
    assign tx_ready = armed && (state == IDLE);
    assign tx_busy  = (state != IDLE);
    assign tx_done  = (state == DONE);

    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        state_nxt       = state;
        os_count_nxt    = os_count;
        bit_index_nxt   = bit_index;
        stop_second_nxt = stop_second;

        if (tick_16x && (state inside {START, DATA, PARITY, STOP}))
            os_count_nxt = os_count + 1'b1;

        unique case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt       = START;
                    os_count_nxt    = '0;
                    bit_index_nxt   = '0;
                    stop_second_nxt = 1'b0;
                end
            end
            START: begin
                if (bit_end) begin
                    state_nxt     = DATA;
                    os_count_nxt  = '0;
                    bit_index_nxt = '0;
                end
            end
            DATA: begin
                if (bit_end) begin
                    os_count_nxt = '0;
                    if (bit_index == IDX_LAST) begin
                        bit_index_nxt = '0;
                        state_nxt     = parity_q ? PARITY : STOP;
                    end else begin
                        bit_index_nxt = bit_index + 1'b1;
                    end
                end
            end
            PARITY: begin
                if (bit_end) begin
                    state_nxt    = STOP;
                    os_count_nxt = '0;
                end
            end
            STOP: begin
                if (bit_end) begin
                    os_count_nxt = '0;
                    if (two_stop_q && !stop_second) begin
                        stop_second_nxt = 1'b1;
                    end else begin
                        stop_second_nxt = 1'b0;
                        state_nxt       = DONE;
                    end
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Line level is derived from the next state so the registered pin moves with the state.
    always_comb begin
        pin_nxt = 1'b1;
        case (state_nxt)
            START:   pin_nxt = 1'b0;
            DATA:    pin_nxt = data_q[bit_index_nxt];
            PARITY:  pin_nxt = ~^data_q;
            default: pin_nxt = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            os_count    <= '0;
            bit_index   <= '0;
            stop_second <= 1'b0;
            tx_pin      <= 1'b1;
            armed       <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all flops sample the same pre-edge values.
            state       <= state_nxt;
            os_count    <= os_count_nxt;
            bit_index   <= bit_index_nxt;
            stop_second <= stop_second_nxt;
            tx_pin      <= pin_nxt;
            armed       <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_q     <= '0;
            parity_q   <= 1'b0;
            two_stop_q <= 1'b0;
        end else if (accept) begin
            data_q     <= tx_data;
            parity_q   <= parity_enable;
            two_stop_q <= two_stop;
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: directed frame table, hand-written reset/freeze/ignore
// sequences, and randomized frames checked against a bit-list reference model.
`timescale 1ns/1ps

module tb_uart_tx;

    typedef struct {
        logic [7:0]  data;
        logic        par;
        logic        two;
        logic        hold;
        int          pulse_at;
        int          freeze_at;
        logic [11:0] bits;
        int          len;
    } frame_t;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       tick_16x;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       parity_enable;
    logic       two_stop;
    logic       tx_ready;
    logic       tx_pin;
    logic       tx_busy;
    logic       tx_done;

    int  n_total = 0;
    int  n_pass  = 0;
    logic tick_en   = 1'b1;
    logic tick_rand = 1'b0;
    int  tick_phase = 0;

    uart_tx #(.DATA_BITS(8), .OVS_FACTOR(16)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .tick_16x     (tick_16x),
        .tx_valid     (tx_valid),
        .tx_data      (tx_data),
        .parity_enable(parity_enable),
        .two_stop     (two_stop),
        .tx_ready     (tx_ready),
        .tx_pin       (tx_pin),
        .tx_busy      (tx_busy),
        .tx_done      (tx_done)
    );

    always #5 clk = ~clk;

    // Strobe is updated on the falling edge so it is stable at the next rising edge.
    always @(negedge clk) begin
        if (!tick_en) begin
            tick_16x = 1'b0;
        end else if (tick_rand) begin
            tick_16x = ($urandom_range(0, 2) == 0);
        end else begin
            tick_phase = (tick_phase + 1) % 4;
            tick_16x   = (tick_phase == 0);
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish (got timeout, required completion)");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    endtask

    // Reference: frame as a list of line levels, first transmitted bit at index 0.
    function automatic void model(input logic [7:0] d, input logic p, input logic s,
                                  output logic [11:0] bits, output int len);
        int n = 0;
        int ones = 0;
        bits = '1;
        bits[n] = 1'b0; n = n + 1;
        for (int i = 0; i < 8; i++) begin
            bits[n] = d[i];
            ones = ones + int'(d[i]);
            n = n + 1;
        end
        if (p) begin
            bits[n] = (ones % 2 == 0);
            n = n + 1;
        end
        bits[n] = 1'b1; n = n + 1;
        if (s) begin
            bits[n] = 1'b1;
            n = n + 1;
        end
        len = n;
    endfunction

    // Offers one frame, then follows it tick by tick; returns cycles spent waiting for tx_ready.
    task automatic run_frame(input int id, input frame_t f, output int waited);
        logic [11:0] seen;
        logic        glitch, early_done, pulse_on, bit_val, frozen_bad, p0;
        int          k, guard;
        seen = '1; glitch = 0; early_done = 0; pulse_on = 0; bit_val = 1'b1; frozen_bad = 0;
        waited = 0;
        tx_data = f.data; parity_enable = f.par; two_stop = f.two; tx_valid = 1'b1;
        while (!tx_ready && waited < 200) begin
            @(negedge clk); #1; waited++;
        end
        if (!tx_ready) begin
            check($sformatf("frame%0d ready_timeout", id), tx_ready, 1);
            tx_valid = 1'b0;
            return;
        end
        @(negedge clk); #1;
        if (!f.hold) tx_valid = 1'b0;
        tx_data = ~f.data; parity_enable = ~f.par; two_stop = ~f.two;
        check($sformatf("frame%0d start {ready,busy,pin}", id), {tx_ready, tx_busy, tx_pin}, 3'b010);
        k = 0; guard = 0;
        while (k < f.len * 16 && guard < f.len * 16 * 16) begin
            if (pulse_on) begin tx_valid = 1'b0; pulse_on = 0; end
            if (tx_done) early_done = 1;
            if (tick_16x) begin
                k++;
                if ((k - 1) % 16 == 0) bit_val = tx_pin;
                else if (tx_pin !== bit_val) glitch = 1;
                if ((k - 1) % 16 == 8) seen[(k - 1) / 16] = tx_pin;
                if (k == f.pulse_at) begin tx_valid = 1'b1; tx_data = 8'hFF; pulse_on = 1; end
                if (k == f.freeze_at) begin
                    tick_en = 1'b0;
                    p0 = tx_pin;
                    repeat (150) begin
                        @(negedge clk); #1;
                        if (tx_pin !== p0 || tx_done) frozen_bad = 1;
                    end
                    tick_en = 1'b1;
                    check($sformatf("frame%0d freeze_stable", id), frozen_bad, 0);
                end
            end
            @(negedge clk); #1; guard++;
        end
        check($sformatf("frame%0d tick_count", id), k, f.len * 16);
        check($sformatf("frame%0d bits", id), seen, f.bits);
        check($sformatf("frame%0d glitch", id), glitch, 0);
        check($sformatf("frame%0d early_done", id), early_done, 0);
        check($sformatf("frame%0d done {done,pin,busy,ready}", id),
              {tx_done, tx_pin, tx_busy, tx_ready}, 4'b1110);
        @(negedge clk); #1;
        check($sformatf("frame%0d idle {done,ready,busy,pin}", id),
              {tx_done, tx_ready, tx_busy, tx_pin}, 4'b0101);
    endtask

    frame_t tbl[7];
    frame_t fr;
    int     waited, k, guard;
    logic   saw_done;

    initial begin
        //         data   par   two   hold  pulse freeze bits (index 0 sent first)  len
        tbl[0] = '{8'hA5, 1'b0, 1'b0, 1'b0, 0,    0,     12'b11_1101001010,         10};
        tbl[1] = '{8'h03, 1'b1, 1'b0, 1'b0, 0,    0,     12'b1_11000000110,         11};
        tbl[2] = '{8'h07, 1'b1, 1'b0, 1'b0, 0,    0,     12'b1_10000001110,         11};
        tbl[3] = '{8'h00, 1'b0, 1'b1, 1'b0, 0,    0,     12'b1_11000000000,         11};
        tbl[4] = '{8'h55, 1'b0, 1'b0, 1'b1, 0,    0,     12'b11_1010101010,         10};
        tbl[5] = '{8'hAA, 1'b0, 1'b0, 1'b0, 0,    0,     12'b11_1101010100,         10};
        tbl[6] = '{8'h81, 1'b1, 1'b0, 1'b0, 40,   100,   12'b1_11100000010,         11};

        reset_n = 1'b0; tx_valid = 1'b0; tx_data = '0; parity_enable = 1'b0; two_stop = 1'b0;
        tick_16x = 1'b0;
        #12;
        check("reset {pin,ready,busy,done}", {tx_pin, tx_ready, tx_busy, tx_done}, 4'b1000);
        @(negedge clk); #1;
        reset_n = 1'b1;
        check("ready_before_first_edge", tx_ready, 0);
        @(negedge clk); #1;
        check("ready_after_first_edge", tx_ready, 1);

        for (int i = 0; i < 7; i++) begin
            run_frame(i, tbl[i], waited);
            if (i > 0 && tbl[i - 1].hold) check($sformatf("frame%0d b2b_wait", i), waited, 0);
        end

        // Reset in the middle of data bit 3 of an all-zero frame.
        tx_data = 8'h00; parity_enable = 1'b0; two_stop = 1'b0; tx_valid = 1'b1;
        guard = 0;
        while (!tx_ready && guard < 200) begin @(negedge clk); #1; guard++; end
        @(negedge clk); #1;
        tx_valid = 1'b0;
        k = 0; guard = 0;
        while (k < 72 && guard < 2000) begin
            if (tick_16x) k++;
            @(negedge clk); #1; guard++;
        end
        check("rst_mid pre_pin", tx_pin, 0);
        reset_n = 1'b0;
        #1;
        check("rst_mid async {pin,busy,ready,done}", {tx_pin, tx_busy, tx_ready, tx_done}, 4'b1000);
        saw_done = 1'b0;
        repeat (3) begin @(negedge clk); #1; if (tx_done) saw_done = 1'b1; end
        reset_n = 1'b1;
        repeat (5) begin @(negedge clk); #1; if (tx_done) saw_done = 1'b1; end
        check("rst_mid no_done", saw_done, 0);
        check("rst_mid idle {ready,busy,pin}", {tx_ready, tx_busy, tx_pin}, 3'b101);
        fr = '{8'h3C, 1'b0, 1'b0, 1'b0, 0, 0, 12'b11_1001111000, 10};
        run_frame(7, fr, waited);

        // Randomized frames with irregular strobe spacing.
        tick_rand = 1'b1;
        for (int i = 0; i < 12; i++) begin
            fr.data = 8'($urandom);
            fr.par  = 1'($urandom_range(0, 1));
            fr.two  = 1'($urandom_range(0, 1));
            fr.hold = 1'b0; fr.pulse_at = 0; fr.freeze_at = 0;
            model(fr.data, fr.par, fr.two, fr.bits, fr.len);
            run_frame(100 + i, fr, waited);
            repeat ($urandom_range(0, 5)) @(negedge clk);
            #1;
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
